// File: rtl/hazard_sequencer.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: load-use bubbles,
// taken-branch squashes, data-memory waits with timeout, and perf counters.
module hazard_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             EX_MemoryRead,
    input  logic [4:0]       EX_rt,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic [5:0]       ID_Op,
    input  logic             EX_BranchTaken,
    input  logic             MEM_Request,
    input  logic             MEM_Ready,
    output logic             PC_WriteEnable,
    output logic             IFID_WriteEnable,
    output logic             IDEX_WriteEnable,
    output logic             EXMEM_WriteEnable,
    output logic             IFID_Flush,
    output logic             IDEX_Flush,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    localparam logic [5:0]       OP_LW    = 6'b100011;
    localparam logic [5:0]       OP_XORI  = 6'b001110;
    localparam logic [7:0]       WAIT_MAX = 8'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    logic use_rt;
    logic load_use;
    logic freeze;

    assign use_rt   = !(ID_Op == OP_LW || ID_Op == OP_XORI);
    assign load_use = EX_MemoryRead && (EX_rt == ID_rs || (use_rt && EX_rt == ID_rt));
    assign freeze   = (state_q == RUN || state_q == MEM_WAIT) && MEM_Request && !MEM_Ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            wait_q    <= 8'd0;
            timeout_q <= 1'b0;
            stall_q   <= '0;
            flush_q   <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
        end
    end

    // Pipeline enables/flushes, priority: reset > HALT > freeze > branch > loadUse.
    always_comb begin
        PC_WriteEnable    = 1'b1;
        IFID_WriteEnable  = 1'b1;
        IDEX_WriteEnable  = 1'b1;
        EXMEM_WriteEnable = 1'b1;
        IFID_Flush        = 1'b0;
        IDEX_Flush        = 1'b0;
        if (reset) begin
            IFID_Flush = 1'b1;
            IDEX_Flush = 1'b1;
        end else if (state_q == HALT || freeze) begin
            PC_WriteEnable    = 1'b0;
            IFID_WriteEnable  = 1'b0;
            IDEX_WriteEnable  = 1'b0;
            EXMEM_WriteEnable = 1'b0;
        end else if (EX_BranchTaken) begin
            // The ID instruction is squashed, so a coincident load-use is moot.
            IFID_Flush = 1'b1;
            IDEX_Flush = 1'b1;
        end else if (load_use) begin
            PC_WriteEnable   = 1'b0;
            IFID_WriteEnable = 1'b0;
            IDEX_Flush       = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        timeout_d = timeout_q;
        case (state_q)
            RUN: begin
                if (freeze) begin
                    state_d = MEM_WAIT;
                    wait_d  = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (MEM_Ready) begin
                    state_d = RUN;
                    wait_d  = 8'd0;
                end else if (wait_q >= WAIT_MAX) begin
                    state_d   = HALT;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            default: begin
                state_d = HALT;
            end
        endcase
    end

    // Counters saturate; HALT freezes them because its cycles are excluded.
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (state_q != HALT && !PC_WriteEnable && stall_q != CNT_MAX)
            stall_d = stall_q + 1'b1;
        if (IFID_Flush && flush_q != CNT_MAX)
            flush_d = flush_q + 1'b1;
    end

    assign MemTimeout = timeout_q;
    assign StallCount = stall_q;
    assign FlushCount = flush_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Scoreboard bench for hazard_sequencer: directed scenarios then random
// traffic, checked against a cycle-level behavioural model.
module tb_hazard_sequencer;

    localparam int TO = 4;
    localparam int CW = 5;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          EX_MemoryRead = 1'b0;
    logic [4:0]    EX_rt = '0, ID_rs = '0, ID_rt = '0;
    logic [5:0]    ID_Op = '0;
    logic          EX_BranchTaken = 1'b0, MEM_Request = 1'b0, MEM_Ready = 1'b0;
    logic          PC_WriteEnable, IFID_WriteEnable, IDEX_WriteEnable, EXMEM_WriteEnable;
    logic          IFID_Flush, IDEX_Flush, MemTimeout;
    logic [CW-1:0] StallCount, FlushCount;

    always #5 clk = ~clk;

    hazard_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .EX_MemoryRead(EX_MemoryRead), .EX_rt(EX_rt), .ID_rs(ID_rs), .ID_rt(ID_rt),
        .ID_Op(ID_Op), .EX_BranchTaken(EX_BranchTaken),
        .MEM_Request(MEM_Request), .MEM_Ready(MEM_Ready),
        .PC_WriteEnable(PC_WriteEnable), .IFID_WriteEnable(IFID_WriteEnable),
        .IDEX_WriteEnable(IDEX_WriteEnable), .EXMEM_WriteEnable(EXMEM_WriteEnable),
        .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush),
        .MemTimeout(MemTimeout), .StallCount(StallCount), .FlushCount(FlushCount)
    );

    typedef struct {
        logic [5:0] ctl;
        bit         mto;
        int         stall;
        int         flush;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Model state: plain flags and integers.
    bit m_halt = 0, m_wait = 0, m_to = 0;
    int m_wlen = 0, m_stall = 0, m_flush = 0;

    task automatic step(input bit rst, input bit mr, input int ert, input int irs,
                        input int irt, input int op, input bit br, input bit req,
                        input bit rdy);
        exp_t e;
        bit   lu, rt_used;
        @(posedge clk);
        #1;
        reset = rst; EX_MemoryRead = mr; EX_rt = 5'(ert); ID_rs = 5'(irs);
        ID_rt = 5'(irt); ID_Op = 6'(op); EX_BranchTaken = br;
        MEM_Request = req; MEM_Ready = rdy;
        rt_used = !(op == 35 || op == 14);
        lu = mr && (ert == irs || (rt_used && ert == irt));
        // ctl = {PC, IFID, IDEX, EXMEM enables, IFID_Flush, IDEX_Flush}
        if (rst)                e.ctl = 6'b111111;
        else if (m_halt)        e.ctl = 6'b000000;
        else if (req && !rdy)   e.ctl = 6'b000000;
        else if (br)            e.ctl = 6'b111111;
        else if (lu)            e.ctl = 6'b001101;
        else                    e.ctl = 6'b111100;
        e.mto = m_to; e.stall = m_stall; e.flush = m_flush;
        q.push_back(e);
        if (rst) begin
            m_halt = 0; m_wait = 0; m_to = 0; m_wlen = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (!m_halt && !e.ctl[5] && m_stall < CMAX) m_stall++;
            if (e.ctl[1] && m_flush < CMAX) m_flush++;
            if (m_halt) begin
            end else if (m_wait) begin
                if (rdy) m_wait = 0;
                else if (m_wlen == TO) begin m_wait = 0; m_halt = 1; m_to = 1; end
                else m_wlen++;
            end else if (req && !rdy) begin
                m_wait = 1; m_wlen = 1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 1, 2, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [5:0] act;
        if (q.size() > 0) begin
            e = q.pop_front();
            act = {PC_WriteEnable, IFID_WriteEnable, IDEX_WriteEnable,
                   EXMEM_WriteEnable, IFID_Flush, IDEX_Flush};
            n_tests += 4;
            if (act !== e.ctl) begin
                n_fail++;
                $display("FAIL ctl t=%0t got %b want %b", $time, act, e.ctl);
            end
            if (MemTimeout !== e.mto) begin
                n_fail++;
                $display("FAIL MemTimeout t=%0t got %b want %b", $time, MemTimeout, e.mto);
            end
            if ($isunknown(StallCount) || int'(StallCount) != e.stall) begin
                n_fail++;
                $display("FAIL StallCount t=%0t got %0d want %0d", $time, StallCount, e.stall);
            end
            if ($isunknown(FlushCount) || int'(FlushCount) != e.flush) begin
                n_fail++;
                $display("FAIL FlushCount t=%0t got %0d want %0d", $time, FlushCount, e.flush);
            end
        end
    end

    initial begin
        int  mode;
        bit  req, rdy, rst;
        // Unchecked reset so DUT registers are defined before scoreboarding.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        do_reset();
        idle(2);

        // Load-use on rs, then the bubble cycle with EX_MemoryRead=0.
        step(0, 1, 8, 8, 0, 0, 0, 0, 0);
        step(0, 0, 8, 8, 0, 0, 0, 0, 0);
        idle(1);

        // rt rule: R-type reads rt; LW and XORI do not.
        step(0, 1, 9, 3, 9, 0, 0, 0, 0);
        step(0, 1, 9, 3, 9, 35, 0, 0, 0);
        step(0, 1, 9, 3, 9, 14, 0, 0, 0);
        step(0, 1, 0, 0, 7, 14, 0, 0, 0);   // register 0 still matches

        // Branch squashes a coincident load-use.
        step(0, 1, 8, 8, 8, 0, 1, 0, 0);
        idle(1);

        // Four-cycle memory wait, then completion; ready-with-request is no stall.
        for (int i = 0; i < 4; i++) step(0, 1, 8, 8, 0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 2, 0, 0, 1, 1);
        step(0, 0, 0, 1, 2, 0, 0, 1, 1);
        idle(2);

        // Timeout: Ready held low until HALT, then hold in HALT, then reset.
        for (int i = 0; i < TO + 5; i++) step(0, 1, 8, 8, 0, 0, 1, 1, 0);
        idle(3);
        do_reset();
        idle(2);

        // Reset in the middle of a wait abandons the access.
        for (int i = 0; i < 2; i++) step(0, 0, 0, 1, 2, 0, 0, 1, 0);
        do_reset();
        idle(2);

        // Counter saturation.
        for (int i = 0; i < CMAX + 8; i++) step(0, 1, 5, 5, 0, 0, 0, 0, 0);
        for (int i = 0; i < CMAX + 8; i++) step(0, 0, 0, 1, 2, 0, 1, 0, 0);
        idle(2);
        do_reset();

        // Random traffic.
        mode = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 97 == 0) mode = $urandom_range(0, 2);
            rst = ($urandom_range(0, 59) == 0);
            req = m_wait ? 1'b1 : ($urandom_range(0, 3) == 0);
            rdy = (mode == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
            step(rst, $urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), ($urandom_range(0, 2) == 0) ? 35 :
                 (($urandom_range(0, 1) == 0) ? 14 : 0),
                 $urandom_range(0, 4) == 0, req, rdy);
        end
        idle(1);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain queue left %0d want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
